dmem_responder: RTL and testbench

- Memory-side responder for the CPU data-memory port; the slave end of the load/store request interface.
- Accepts one word read or write request via a valid/ready handshake and holds it for a programmable latency.
- Returns the response (read data or write acknowledge, plus an error flag) on a second valid/ready channel.
- Sits between the core's load/store path and a word-addressed storage array. The array lives inside the block.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/latency_counter.sv | 47 ++++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Definitions shared by the data-memory responder and its latency counter:
//   - resp_state_t  : responder FSM states
//   - WORD_OFF_BITS : byte-offset bits below the word index
//   - addr_ok()     : 1 when a byte address is word-aligned and inside the array
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam int unsigned WORD_OFF_BITS = 2;

    // Returns 1 for a legal access. The caller flags an error when this is 0.
    // The bound is computed in 34 bits so NUMWORDS*4 cannot overflow.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned numwords);
        logic [33:0] limit;
        limit = 34'(numwords) << WORD_OFF_BITS;
        return (addr[WORD_OFF_BITS-1:0] == '0) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/latency_counter.sv
// -----------------------------------------------------------------------------
// latency_counter
// Loadable down-counter with a zero flag. It saturates at zero. It only takes
// a new value through load_i.
// Ports:
//   clk_i       in   clock
//   rst_ni      in   asynchronous reset, active-low (count -> 0)
//   load_i      in   load load_val_i this cycle (has priority over dec_i)
//   load_val_i  in   value to load
//   dec_i       in   decrement this cycle (ignored at zero)
//   zero_o      out  count is zero
// -----------------------------------------------------------------------------
module latency_counter #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Slave end of the CPU data-memory port. The block accepts one word read or
// write. It waits LATENCY cycles and then returns read data or a write
// acknowledge with an error flag. The word array is inside this block.
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous reset, active-low (also clears the array)
//   req_valid_i  in   request present
//   req_ready_o  out  request can be accepted (IDLE and out of reset)
//   req_we_i     in   1 = write, 0 = read
//   req_addr_i   in   byte address
//   req_wdata_i  in   write data
//   rsp_valid_o  out  response present
//   rsp_ready_i  in   requester consumes the response
//   rsp_rdata_o  out  read data; 0 for writes and errors
//   rsp_err_o    out  access was misaligned or out of range
// -----------------------------------------------------------------------------
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned NUMWORDS  = 32,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [31:0]          req_addr_i,
    input  logic [DATAWIDTH-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_rdata_o,
    output logic                 rsp_err_o
);

    localparam int unsigned IDX_W = $clog2(NUMWORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // WAIT lasts LATENCY-1 cycles: the counter runs from LATENCY-2 down to 0.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    resp_state_t          state_q, state_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic [DATAWIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [DATAWIDTH-1:0] mem_q [NUMWORDS];
    logic [DATAWIDTH-1:0] mem_d [NUMWORDS];

    logic                 ready_state;
    logic                 commit;
    logic                 cnt_load, cnt_dec, cnt_zero;

    // Operands of the commit. With LATENCY=1 the commit happens on the
    // acceptance edge, so the values come straight from the request port.
    // Otherwise they come from the latched copy.
    logic                 c_we;
    logic [31:0]          c_addr;
    logic [DATAWIDTH-1:0] c_wdata;
    logic [IDX_W-1:0]     c_idx;
    logic                 c_ok;

    latency_counter #(.WIDTH(CNT_W)) u_latency_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (CNT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // NOTE: every signal written in a combinational block gets a default first; otherwise a latch is inferred.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ready_state = 1'b0;
        commit      = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_state = 1'b1;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d  = WAIT;
                        cnt_load = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        c_we    = (state_q == IDLE) ? req_we_i    : we_q;
        c_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
        c_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
        c_idx   = c_addr[IDX_W+WORD_OFF_BITS-1:WORD_OFF_BITS];
        c_ok    = addr_ok(c_addr, NUMWORDS);

        rdata_d = rdata_q;
        err_d   = err_q;
        mem_d   = mem_q;
        if (commit) begin
            err_d   = !c_ok;
            rdata_d = '0;
            if (c_ok) begin
                if (c_we) begin
                    mem_d[c_idx] = c_wdata;
                end else begin
                    rdata_d = mem_q[c_idx];
                end
            end
        end
    end

    // NOTE: the array is reset like any other state because a reset must clear it; this keeps it in flops rather than RAM macros.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < int'(NUMWORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    // Gated by the reset so that ready is low while reset is held, although
    // the state register already reads IDLE.
    assign req_ready_o = ready_state && rst_ni;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Three responders share one clock and one reset: LATENCY = 1, 2 and 4
// (index 0, 1, 2). Each has its own request/response signals. Directed
// scenarios compare against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_we = '0;
    logic [2:0]  rsp_ready = 3'b111;
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    wire  [2:0]  req_ready_w;
    wire  [2:0]  rsp_valid_w;
    wire  [2:0]  rsp_err_w;
    wire  [31:0] rsp_rdata_w [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .NUMWORDS  (32),
            .DATAWIDTH (32),
            .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready_w[g]),
            .req_we_i    (req_we[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .rsp_valid_o (rsp_valid_w[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_rdata_o (rsp_rdata_w[g]),
            .rsp_err_o   (rsp_err_w[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request on instance k. lat is the number of edges from the
    // acceptance edge until rsp_valid is seen, including the acceptance edge.
    // If rsp_ready is high, the task also completes the response handshake.
    task automatic txn(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat,
                       output logic [31:0] rd, output logic er);
        checks++;
        if (req_ready_w[k] !== 1'b1) begin
            errors++;
            $display("FAIL txn_ready k=%0d: req_ready=%b want 1", k, req_ready_w[k]);
        end
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        step();
        req_valid[k] = 1'b0;
        lat = 1;
        while (rsp_valid_w[k] !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        checks++;
        if (lat >= 40) begin
            errors++;
            $display("FAIL txn_timeout k=%0d addr=%h: rsp_valid never rose", k, addr);
        end
        rd = rsp_rdata_w[k];
        er = rsp_err_w[k];
        if (rsp_ready[k]) step();
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (req_ready_w !== 3'b000 || rsp_valid_w !== 3'b000 || rsp_err_w !== 3'b000) begin
            errors++;
            $display("FAIL reset_held: ready=%b valid=%b err=%b want 000 000 000",
                     req_ready_w, rsp_valid_w, rsp_err_w);
        end
        checks++;
        if (rsp_rdata_w[1] !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", rsp_rdata_w[1]);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready_w !== 3'b111 || rsp_valid_w !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b want 111 000", req_ready_w, rsp_valid_w);
        end
        step();
    endtask

    task automatic test_write_read();
        int lat;
        logic [31:0] rd;
        logic er;
        txn(1, 1'b1, 32'h8, 32'hDEADBEEF, lat, rd, er);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL wr_rsp: lat=%0d err=%b rdata=%h want 2 0 00000000", lat, er, rd);
        end
        checks++;
        if (req_ready_w[1] !== 1'b1 || rsp_valid_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle: ready=%b valid=%b want 1 0", req_ready_w[1], rsp_valid_w[1]);
        end
        txn(1, 1'b0, 32'h8, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL rd_after_wr: rdata=%h err=%b lat=%0d want deadbeef 0 2", rd, er, lat);
        end
    endtask

    task automatic test_errors();
        int lat;
        logic [31:0] rd;
        logic er;
        txn(1, 1'b1, 32'h6, 32'h11111111, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL misaligned_wr: err=%b rdata=%h want 1 0", er, rd);
        end
        txn(1, 1'b0, 32'h4, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL misaligned_no_commit: err=%b rdata=%h want 0 0", er, rd);
        end
        txn(1, 1'b0, 32'h80, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL out_of_range_rd: err=%b rdata=%h want 1 0", er, rd);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] rd;
        logic er;
        txn(1, 1'b1, 32'hC, 32'hCAFEF00D, lat, rd, er);
        rsp_ready[1] = 1'b0;
        txn(1, 1'b0, 32'hC, 32'h0, lat, rd, er);
        for (int i = 0; i < 5; i++) begin
            // This write must be ignored because ready is low.
            req_valid[1] = 1'b1;
            req_we[1]    = 1'b1;
            req_addr[1]  = 32'hC;
            req_wdata[1] = 32'hBAD0BAD0;
            checks++;
            if (rsp_valid_w[1] !== 1'b1 || rsp_rdata_w[1] !== 32'hCAFEF00D ||
                rsp_err_w[1] !== 1'b0 || req_ready_w[1] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d: valid=%b rdata=%h err=%b ready=%b want 1 cafef00d 0 0",
                         i, rsp_valid_w[1], rsp_rdata_w[1], rsp_err_w[1], req_ready_w[1]);
            end
            step();
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        step();
        checks++;
        if (req_ready_w[1] !== 1'b1 || rsp_valid_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b want 1 0", req_ready_w[1], rsp_valid_w[1]);
        end
        txn(1, 1'b0, 32'hC, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL bp_ignored_wr: rdata=%h err=%b want cafef00d 0", rd, er);
        end
    endtask

    task automatic test_last_word();
        int lat;
        logic [31:0] rd;
        logic er;
        txn(1, 1'b1, 32'h7C, 32'hA5A55A5A, lat, rd, er);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL last_wr: err=%b want 0", er);
        end
        txn(1, 1'b0, 32'h7C, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hA5A55A5A || er !== 1'b0) begin
            errors++;
            $display("FAIL last_rd: rdata=%h err=%b want a5a55a5a 0", rd, er);
        end
        txn(1, 1'b1, 32'h80, 32'h77777777, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL past_last_wr: err=%b rdata=%h want 1 0", er, rd);
        end
    endtask

    task automatic test_latency();
        int lat;
        logic [31:0] rd;
        logic er;
        for (int k = 0; k < 3; k++) begin
            txn(k, 1'b1, 32'h20, 32'h10000001 + k, lat, rd, er);
            checks++;
            if (lat !== lat_of(k)) begin
                errors++;
                $display("FAIL latency k=%0d: got %0d want %0d", k, lat, lat_of(k));
            end
            txn(k, 1'b0, 32'h20, 32'h0, lat, rd, er);
            checks++;
            if (rd !== 32'h10000001 + k || er !== 1'b0 || lat !== lat_of(k)) begin
                errors++;
                $display("FAIL lat_rd k=%0d: rdata=%h err=%b lat=%0d want %h 0 %0d",
                         k, rd, er, lat, 32'h10000001 + k, lat_of(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        int first, second, t;
        for (int k = 0; k < 3; k++) begin
            first  = -1;
            second = -1;
            req_valid[k] = 1'b1;
            req_we[k]    = 1'b0;
            req_addr[k]  = 32'h20;
            for (t = 0; t < 16 && second < 0; t++) begin
                if (req_ready_w[k] === 1'b1) begin
                    if (first < 0) first = t;
                    else second = t;
                end
                step();
            end
            req_valid[k] = 1'b0;
            checks++;
            if (first < 0 || second < 0 || (second - first) !== lat_of(k) + 1) begin
                errors++;
                $display("FAIL b2b_spacing k=%0d: got %0d want %0d", k, second - first, lat_of(k) + 1);
            end
            for (t = 0; t < 16 && !(req_ready_w[k] === 1'b1 && rsp_valid_w[k] === 1'b0); t++) begin
                step();
            end
            checks++;
            if (req_ready_w[k] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_drain k=%0d: ready=%b want 1", k, req_ready_w[k]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        logic [31:0] rd;
        logic er;
        rsp_ready[0] = 1'b0;
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h10; req_wdata[2] = 32'h12345678;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h20;
        step();
        req_valid = '0;
        step();
        step();
        checks++;
        if (rsp_valid_w[0] !== 1'b1 || rsp_valid_w[2] !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: valid0=%b valid2=%b want 1 0", rsp_valid_w[0], rsp_valid_w[2]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid_w !== 3'b000 || req_ready_w !== 3'b000 || rsp_rdata_w[0] !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%b ready=%b rdata0=%h want 000 000 0",
                     rsp_valid_w, req_ready_w, rsp_rdata_w[0]);
        end
        step();
        step();
        rst_n = 1'b1;
        rsp_ready[0] = 1'b1;
        step();
        txn(2, 1'b0, 32'h10, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL dropped_wr: rdata=%h err=%b lat=%0d want 0 0 4", rd, er, lat);
        end
        txn(0, 1'b0, 32'h20, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL array_cleared_l1: rdata=%h want 0", rd);
        end
        txn(1, 1'b0, 32'h8, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL array_cleared_l2: rdata=%h want 0", rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end
        test_reset();
        test_write_read();
        test_errors();
        test_backpressure();
        test_last_word();
        test_latency();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
